traffic_light_controller: RTL and testbench
===========================================

TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 Parameter T_MG, default 7: cycles for main-both-green phase (S1).
REQ-002 Parameter T_Y, default 2: cycles for every yellow phase (S2, S4, S6).
REQ-003 Parameter T_TG, default 5: cycles for main-turn-green phase (S3).
REQ-004 Parameter T_SG, default 3: cycles for side-green phase (S5).
REQ-005 clk  input  1  single system clock; one cycle = 1 s; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 light_M1  output  3  main road direction 1 lamp.
REQ-008 light_M2  output  3  main road direction 2 lamp.
REQ-009 light_MT  output  3  main road turn lamp.
REQ-010 light_S  output  3  side road lamp.
REQ-011 Lamp encoding on every output: 3'b100 = red, 3'b010 = yellow, 3'b001 = green; no other codes driven.

Function
REQ-012 Six-state Moore FSM, S1..S6; outputs are a pure decode of the current state, with no combinational path from inputs.
REQ-013 S1: M1 = green, M2 = green, MT = red, S = red; duration T_MG; next S2.
REQ-014 S2: M1 = green, M2 = yellow, MT = red, S = red; duration T_Y; next S3.
REQ-015 S3: M1 = green, M2 = red, MT = green, S = red; duration T_TG; next S4.
REQ-016 S4: M1 = yellow, M2 = red, MT = yellow, S = red; duration T_Y; next S5.
REQ-017 S5: M1 = red, M2 = red, MT = red, S = green; duration T_SG; next S6.
REQ-018 S6: M1 = red, M2 = red, MT = red, S = yellow; duration T_Y; next S1.
REQ-019 Dwell counter: on each rising edge, if count == D-1 (D = current state duration), state advances and count clears to 0; otherwise count increments by 1.
REQ-020 Each state is held for exactly D rising edges after entry; with defaults, one full cycle is 21 clocks.
REQ-021 Counter width: at least 4 bits and large enough to hold max(parameters)-1 without overflow.
REQ-022 All parameters must be >= 1; a value of 1 gives a single-cycle phase.
REQ-023 Safety invariant: S is never green or yellow while any main lamp is green or yellow, and MT and M2 are never simultaneously non-red.
REQ-024 Any unreachable or illegal state encoding returns to S1 with count 0 on the next rising edge; the outputs decode that encoding as all-red.

Reset
REQ-025 reset = 1 immediately (without waiting for a clock edge) forces state S1 and count 0.
REQ-026 During reset the outputs are M1 = 3'b001, M2 = 3'b001, MT = 3'b100, S = 3'b100.
REQ-027 While reset stays high, the FSM does not advance.
REQ-028 After reset deasserts, the first rising edge counts as S1 cycle 1, so the FSM enters S2 on the 7th rising edge with defaults.
REQ-029 Reset asserted mid-phase (any state, any count) aborts the phase and restarts at S1 with count 0.

Verification
REQ-030 Pulse reset high for 1 cycle, then low -> outputs M1/M2 = 001, MT/S = 100 for 7 edges, then M2 = 010.
REQ-031 Run 21 edges from reset release -> state sequence S1 x7, S2 x2, S3 x5, S4 x2, S5 x3, S6 x2, back to S1 on edge 21.
REQ-032 Monitor all outputs every cycle over 3 full cycles -> safety invariant REQ-023 never violated; only codes 100/010/001 appear.
REQ-033 Assert reset asynchronously between edges while in S5 -> outputs return to S1 values before the next clock edge; S1 then lasts a full 7 cycles.
REQ-034 Hold reset high for 10 edges -> outputs stay at S1 values; no state change.
REQ-035 Set parameters to T_MG=1, T_Y=1, T_TG=1, T_SG=1 -> state changes every clock; the 6-state cycle repeats every 6 edges.

Source files
------------

// File: rtl/traffic_light_controller.sv
// Three-road traffic light controller: six-phase Moore FSM with a per-phase
// dwell counter. Lamp codes are 100 = red, 010 = yellow, 001 = green.
module traffic_light_controller #(
  parameter int T_MG = 7,  // main both green
  parameter int T_Y  = 2,  // every yellow phase
  parameter int T_TG = 5,  // main turn green
  parameter int T_SG = 3   // side green
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S
);

  localparam int T_MAX_A = (T_MG > T_Y) ? T_MG : T_Y;
  localparam int T_MAX_B = (T_TG > T_SG) ? T_TG : T_SG;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  // The counter never exceeds T_MAX-1; keep at least 4 bits.
  localparam int CW      = ($clog2(T_MAX) > 4) ? $clog2(T_MAX) : 4;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [2:0] {
    S1 = 3'd0,
    S2 = 3'd1,
    S3 = 3'd2,
    S4 = 3'd3,
    S5 = 3'd4,
    S6 = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   dwell_last;
  logic            at_end;

  // Last count value of the current phase (duration minus one).
  always_comb begin
    dwell_last = '0;
    case (state_q)
      S1:      dwell_last = CW'(T_MG - 1);
      S2:      dwell_last = CW'(T_Y - 1);
      S3:      dwell_last = CW'(T_TG - 1);
      S4:      dwell_last = CW'(T_Y - 1);
      S5:      dwell_last = CW'(T_SG - 1);
      S6:      dwell_last = CW'(T_Y - 1);
      default: dwell_last = '0;
    endcase
  end

  assign at_end = (count_q == dwell_last);

  // Next phase and dwell count; illegal encodings fall back to S1, count 0.
  always_comb begin
    state_d = S1;
    count_d = '0;
    case (state_q)
      S1: begin state_d = at_end ? S2 : S1; count_d = at_end ? '0 : count_q + CW'(1); end
      S2: begin state_d = at_end ? S3 : S2; count_d = at_end ? '0 : count_q + CW'(1); end
      S3: begin state_d = at_end ? S4 : S3; count_d = at_end ? '0 : count_q + CW'(1); end
      S4: begin state_d = at_end ? S5 : S4; count_d = at_end ? '0 : count_q + CW'(1); end
      S5: begin state_d = at_end ? S6 : S5; count_d = at_end ? '0 : count_q + CW'(1); end
      S6: begin state_d = at_end ? S1 : S6; count_d = at_end ? '0 : count_q + CW'(1); end
      default: begin
        state_d = S1;
        count_d = '0;
      end
    endcase
  end

  // State and dwell registers; reset takes effect immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Lamp decode from the current state only; unknown encodings show all red.
  always_comb begin
    light_M1 = RED;
    light_M2 = RED;
    light_MT = RED;
    light_S  = RED;
    case (state_q)
      S1: begin light_M1 = GREEN;  light_M2 = GREEN;  end
      S2: begin light_M1 = GREEN;  light_M2 = YELLOW; end
      S3: begin light_M1 = GREEN;  light_MT = GREEN;  end
      S4: begin light_M1 = YELLOW; light_MT = YELLOW; end
      S5: begin light_S  = GREEN;  end
      S6: begin light_S  = YELLOW; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: a default-timed instance and an
// all-ones-timed instance share clock and reset; both are compared against a
// schedule model driven by the count of clock edges since reset release.
module tb_traffic_light_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [2:0] a_m1, a_m2, a_mt, a_s;
  logic [2:0] b_m1, b_m2, b_mt, b_s;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;  // rising edges seen with reset low since last reset

  traffic_light_controller u_def (
    .clk      (clk),
    .reset    (reset),
    .light_M1 (a_m1),
    .light_M2 (a_m2),
    .light_MT (a_mt),
    .light_S  (a_s)
  );

  traffic_light_controller #(.T_MG(1), .T_Y(1), .T_TG(1), .T_SG(1)) u_one (
    .clk      (clk),
    .reset    (reset),
    .light_M1 (b_m1),
    .light_M2 (b_m2),
    .light_MT (b_mt),
    .light_S  (b_s)
  );

  always #5 clk = ~clk;

  // Lamp pattern {M1,M2,MT,S} of phase k (0..5 = S1..S6).
  function automatic logic [11:0] phase_lamps(int k);
    case (k)
      0: return {3'b001, 3'b001, 3'b100, 3'b100};
      1: return {3'b001, 3'b010, 3'b100, 3'b100};
      2: return {3'b001, 3'b100, 3'b001, 3'b100};
      3: return {3'b010, 3'b100, 3'b010, 3'b100};
      4: return {3'b100, 3'b100, 3'b100, 3'b001};
      default: return {3'b100, 3'b100, 3'b100, 3'b010};
    endcase
  endfunction

  // Expected lamps after e edges from release, given the phase schedule.
  function automatic logic [11:0] expected(int e, int d0, int d1, int d2, int d3, int d4, int d5);
    int durs[6];
    int total;
    int m;
    durs[0] = d0; durs[1] = d1; durs[2] = d2; durs[3] = d3; durs[4] = d4; durs[5] = d5;
    total = d0 + d1 + d2 + d3 + d4 + d5;
    m = e % total;
    for (int k = 0; k < 6; k++) begin
      if (m < durs[k]) return phase_lamps(k);
      m -= durs[k];
    end
    return 12'h000;
  endfunction

  function automatic bit legal_code(logic [2:0] c);
    return (c === 3'b100) || (c === 3'b010) || (c === 3'b001);
  endfunction

  // Safety: side lit only when all main lamps are red; M2 and MT never both lit.
  function automatic bit safe(logic [11:0] v);
    logic [2:0] m1, m2, mt, s;
    {m1, m2, mt, s} = v;
    if (!(legal_code(m1) && legal_code(m2) && legal_code(mt) && legal_code(s))) return 1'b0;
    if (s !== 3'b100 && (m1 !== 3'b100 || m2 !== 3'b100 || mt !== 3'b100)) return 1'b0;
    if (m2 !== 3'b100 && mt !== 3'b100) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag);
    logic [11:0] obs_a, obs_b, exp_a, exp_b;
    obs_a = {a_m1, a_m2, a_mt, a_s};
    obs_b = {b_m1, b_m2, b_mt, b_s};
    exp_a = expected(n, 7, 2, 5, 2, 3, 2);
    exp_b = expected(n, 1, 1, 1, 1, 1, 1);
    vectors++;
    assert (obs_a === exp_a) else begin
      miscompares++;
      $error("FAIL %s default n=%0d observed=%03b_%03b_%03b_%03b expected=%03b_%03b_%03b_%03b",
             tag, n, obs_a[11:9], obs_a[8:6], obs_a[5:3], obs_a[2:0],
             exp_a[11:9], exp_a[8:6], exp_a[5:3], exp_a[2:0]);
    end
    vectors++;
    assert (obs_b === exp_b) else begin
      miscompares++;
      $error("FAIL %s ones n=%0d observed=%03b_%03b_%03b_%03b expected=%03b_%03b_%03b_%03b",
             tag, n, obs_b[11:9], obs_b[8:6], obs_b[5:3], obs_b[2:0],
             exp_b[11:9], exp_b[8:6], exp_b[5:3], exp_b[2:0]);
    end
    vectors++;
    assert (safe(obs_a) === 1'b1) else begin
      miscompares++;
      $error("FAIL %s safety_default observed=%03h expected=safe", tag, obs_a);
    end
    vectors++;
    assert (safe(obs_b) === 1'b1) else begin
      miscompares++;
      $error("FAIL %s safety_ones observed=%03h expected=safe", tag, obs_b);
    end
  endtask

  // One clock edge, model update, then sample 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!reset) n++;
    #1;
    check(tag);
  endtask

  task automatic run(input int k, input string tag);
    for (int i = 0; i < k; i++) tick(tag);
  endtask

  // Raise reset between edges and check outputs before the next edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    n = 0;
    check(tag);
  endtask

  task automatic release_reset();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int len;
    // Reset asserted from time zero.
    #1;
    check("reset_state");
    run(10, "reset_hold");
    release_reset();
    // Three full default cycles, including the S1->S2 step at edge 7.
    run(63, "three_cycles");
    // Walk into S5 (edges 16..18 after release) and reset mid-phase.
    async_reset("reset_enter");
    release_reset();
    run(17, "to_s5");
    async_reset("async_in_s5");
    release_reset();
    run(8, "s1_after_abort");
    // Randomized run lengths and reset pulses.
    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(0, 30);
      run(len, "rand_run");
      async_reset("rand_reset");
      len = $urandom_range(0, 3);
      run(len, "rand_hold");
      release_reset();
    end
    run(25, "tail");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
